// File: rtl/ex_wb_stage.sv
// ex_wb_stage
// Execute and write-back stages of a three-stage RV32I pipeline. Resolves
// operands from an internal 32x32 register file (with a W->E bypass), computes
// ALU/LUI/AUIPC/link results, resolves branches and jumps into a same-cycle
// redirect, runs loads/stores on a req/ack data-memory handshake and registers
// the result into W for the register-file write on the following edge.
//
// Ports:
//   clk, resetb                 pipeline clock, asynchronous active-low reset
//   ex_*                        decoded E-slot fields from fetch/decode
//   stall                       upstream must hold ex_* stable
//   redirect, redirect_pc       taken branch/jump and its target
//   dmem_req/we/addr/wdata/wstrb, dmem_ack, dmem_rdata
//                               data-memory handshake
//   exception                   sticky misaligned access or jump target
module ex_wb_stage (
  input  logic        clk,
  input  logic        resetb,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic        ex_imm_sel,
  input  logic [4:0]  ex_src1_sel,
  input  logic [4:0]  ex_src2_sel,
  input  logic [4:0]  ex_dst_sel,
  input  logic [2:0]  ex_alu_op,
  input  logic        ex_subtype,
  input  logic        ex_memwr,
  input  logic        ex_mem2reg,
  input  logic        ex_alu,
  input  logic        ex_lui,
  input  logic        ex_auipc,
  input  logic        ex_jal,
  input  logic        ex_jalr,
  input  logic        ex_branch,
  output logic        stall,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        exception
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]  state_q, state_d;
  logic        kill_q, kill_d;
  logic        exc_q, exc_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_dst_q, wb_dst_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];

  logic [31:0] rs1_val, rs2_val, op2, alu_res, agu_sum, target, result;
  logic [31:0] rdata_shifted, load_val, wdata_int;
  logic [3:0]  wstrb_int;
  logic [4:0]  shamt;
  logic        live, br_taken, take, tgt_exc, mem_exc, mis, is_mem;
  logic        mem_active, stall_int, redirect_int;

  // Operand read with W->E bypass so a dependent instruction needs no bubble.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (ex_src1_sel != 5'd0)
      rs1_val = (wb_we_q && wb_dst_q == ex_src1_sel) ? wb_data_q : rf_q[ex_src1_sel];
    if (ex_src2_sel != 5'd0)
      rs2_val = (wb_we_q && wb_dst_q == ex_src2_sel) ? wb_data_q : rf_q[ex_src2_sel];
    op2   = ex_imm_sel ? ex_imm : rs2_val;
    shamt = op2[4:0];
  end

  always_comb begin
    alu_res = '0;
    case (ex_alu_op)
      3'd0: alu_res = ex_subtype ? rs1_val - op2 : rs1_val + op2;
      3'd1: alu_res = rs1_val << shamt;
      3'd2: alu_res = {31'd0, $signed(rs1_val) < $signed(op2)};
      3'd3: alu_res = {31'd0, rs1_val < op2};
      3'd4: alu_res = rs1_val ^ op2;
      3'd5: alu_res = ex_subtype ? $unsigned($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
      3'd6: alu_res = rs1_val | op2;
      default: alu_res = rs1_val & op2;
    endcase
  end

  // Branch/jump resolution. A killed wrong-path instruction is treated as a bubble.
  always_comb begin
    br_taken = 1'b0;
    case (ex_alu_op)
      3'd0: br_taken = (rs1_val == rs2_val);
      3'd1: br_taken = (rs1_val != rs2_val);
      3'd4: br_taken = ($signed(rs1_val) < $signed(rs2_val));
      3'd5: br_taken = !($signed(rs1_val) < $signed(rs2_val));
      3'd6: br_taken = (rs1_val < rs2_val);
      3'd7: br_taken = !(rs1_val < rs2_val);
      default: br_taken = 1'b0;
    endcase
    live         = ex_valid && !kill_q;
    agu_sum      = rs1_val + ex_imm;
    target       = ex_jalr ? {agu_sum[31:1], 1'b0} : ex_pc + ex_imm;
    take         = ex_jal || ex_jalr || (ex_branch && br_taken);
    tgt_exc      = live && take && (target[1:0] != 2'b00);
    redirect_int = live && take && (target[1:0] == 2'b00);
  end

  // Load/store: alignment, strobes, lane replication and load extraction.
  always_comb begin
    is_mem     = ex_memwr || ex_mem2reg;
    mis        = ((ex_alu_op[1:0] == 2'd1) && agu_sum[0]) ||
                 ((ex_alu_op[1:0] == 2'd2) && (agu_sum[1:0] != 2'b00));
    mem_exc    = live && is_mem && mis;
    mem_active = live && is_mem && !mis;
    stall_int  = mem_active && !dmem_ack;
    case (ex_alu_op[1:0])
      2'd0: begin
        wstrb_int = 4'b0001 << agu_sum[1:0];
        wdata_int = {4{rs2_val[7:0]}};
      end
      2'd1: begin
        wstrb_int = 4'b0011 << agu_sum[1:0];
        wdata_int = {2{rs2_val[15:0]}};
      end
      default: begin
        wstrb_int = 4'b1111;
        wdata_int = rs2_val;
      end
    endcase
    rdata_shifted = dmem_rdata >> {agu_sum[1:0], 3'b000};
    case (ex_alu_op)
      3'd0: load_val = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'd1: load_val = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'd4: load_val = {24'd0, rdata_shifted[7:0]};
      3'd5: load_val = {16'd0, rdata_shifted[15:0]};
      default: load_val = dmem_rdata;
    endcase
  end

  // Next-state for W, kill, exception, memory FSM and register file.
  always_comb begin
    result = alu_res;
    if (ex_lui)                result = ex_imm;
    else if (ex_auipc)         result = ex_pc + ex_imm;
    else if (ex_jal || ex_jalr) result = ex_pc + 32'd4;
    else if (ex_mem2reg)       result = load_val;

    wb_we_d   = !stall_int && live && !tgt_exc && !mem_exc &&
                (ex_alu || ex_lui || ex_auipc || ex_jal || ex_jalr || ex_mem2reg) &&
                (ex_dst_sel != 5'd0);
    wb_dst_d  = ex_dst_sel;
    wb_data_d = result;
    kill_d    = stall_int ? kill_q : redirect_int;
    exc_d     = exc_q || tgt_exc || mem_exc;

    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mem_active && !dmem_ack) state_d = ST_WAIT;
      default: if (dmem_ack) state_d = ST_IDLE;
    endcase

    rf_d = rf_q;
    if (wb_we_q) rf_d[wb_dst_q] = wb_data_q;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q   <= ST_IDLE;
      kill_q    <= 1'b0;
      exc_q     <= 1'b0;
      wb_we_q   <= 1'b0;
      wb_dst_q  <= '0;
      wb_data_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      kill_q    <= kill_d;
      exc_q     <= exc_d;
      wb_we_q   <= wb_we_d;
      wb_dst_q  <= wb_dst_d;
      wb_data_q <= wb_data_d;
      rf_q      <= rf_d;
    end
  end

  // Combinational outputs are forced low while reset is held, which also drops
  // an in-flight request immediately.
  assign stall       = resetb && stall_int;
  assign redirect    = resetb && redirect_int;
  assign redirect_pc = redirect ? target : '0;
  assign dmem_req    = resetb && mem_active;
  assign dmem_we     = dmem_req && ex_memwr;
  assign dmem_addr   = dmem_req ? agu_sum : '0;
  assign dmem_wdata  = dmem_we ? wdata_int : '0;
  assign dmem_wstrb  = dmem_we ? wstrb_int : '0;
  assign exception   = exc_q;

endmodule

// File: tb/tb_ex_wb_stage.sv
// Testbench for ex_wb_stage: table-driven ALU vectors plus hand-written
// sequences for memory, branch, exception and reset corner cases. Memory
// transactions are checked against a scoreboard; register contents are
// observed by storing them and checking the store data.
module tb_ex_wb_stage;

  logic        clk = 1'b0;
  logic        resetb;
  logic        ex_valid, ex_imm_sel, ex_subtype, ex_memwr, ex_mem2reg;
  logic        ex_alu, ex_lui, ex_auipc, ex_jal, ex_jalr, ex_branch;
  logic [31:0] ex_pc, ex_imm;
  logic [4:0]  ex_src1_sel, ex_src2_sel, ex_dst_sel;
  logic [2:0]  ex_alu_op;
  logic        stall, redirect, dmem_req, dmem_we, dmem_ack, exception;
  logic [31:0] redirect_pc, dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;

  always #5 clk = ~clk;

  ex_wb_stage dut (
    .clk(clk), .resetb(resetb), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_imm_sel(ex_imm_sel), .ex_src1_sel(ex_src1_sel), .ex_src2_sel(ex_src2_sel),
    .ex_dst_sel(ex_dst_sel), .ex_alu_op(ex_alu_op), .ex_subtype(ex_subtype),
    .ex_memwr(ex_memwr), .ex_mem2reg(ex_mem2reg), .ex_alu(ex_alu), .ex_lui(ex_lui),
    .ex_auipc(ex_auipc), .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_branch(ex_branch),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .exception(exception)
  );

  typedef struct {
    logic        valid, imm_sel, sub, memwr, mem2reg, alu, lui, auipc, jal, jalr, branch;
    logic [31:0] pc, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  op;
  } instr_t;

  typedef struct {
    string       tag;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_exp_t;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic        sub, imm_sel, lui, auipc;
    logic [31:0] imm, pc, exp;
  } vec_t;

  mem_exp_t    sb_q[$];
  vec_t        vecs[13];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          stall_cycles;
  logic        samp_redirect, samp_req;
  logic [31:0] samp_redirect_pc;

  function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endfunction

  function automatic instr_t bubble();
    instr_t i;
    i = '{valid: 1'b0, imm_sel: 1'b0, sub: 1'b0, memwr: 1'b0, mem2reg: 1'b0, alu: 1'b0,
          lui: 1'b0, auipc: 1'b0, jal: 1'b0, jalr: 1'b0, branch: 1'b0,
          pc: 32'd0, imm: 32'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, op: 3'd0};
    return i;
  endfunction

  function automatic instr_t mk_alu(logic [2:0] op, logic sub, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    instr_t i = bubble();
    i.valid = 1'b1; i.alu = 1'b1; i.op = op; i.sub = sub; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
    return i;
  endfunction

  function automatic instr_t mk_alui(logic [2:0] op, logic [4:0] rd, logic [4:0] rs1, logic [31:0] imm);
    instr_t i = bubble();
    i.valid = 1'b1; i.alu = 1'b1; i.imm_sel = 1'b1; i.op = op; i.rd = rd; i.rs1 = rs1; i.imm = imm;
    return i;
  endfunction

  function automatic instr_t mk_store(logic [2:0] op, logic [4:0] rs1, logic [4:0] rs2, logic [31:0] imm);
    instr_t i = bubble();
    i.valid = 1'b1; i.memwr = 1'b1; i.imm_sel = 1'b1; i.op = op; i.rs1 = rs1; i.rs2 = rs2; i.imm = imm;
    return i;
  endfunction

  function automatic instr_t mk_load(logic [2:0] op, logic [4:0] rd, logic [4:0] rs1, logic [31:0] imm);
    instr_t i = bubble();
    i.valid = 1'b1; i.mem2reg = 1'b1; i.imm_sel = 1'b1; i.op = op; i.rd = rd; i.rs1 = rs1; i.imm = imm;
    return i;
  endfunction

  function automatic instr_t mk_branch(logic [2:0] op, logic [4:0] rs1, logic [4:0] rs2, logic [31:0] imm, logic [31:0] pc);
    instr_t i = bubble();
    i.valid = 1'b1; i.branch = 1'b1; i.op = op; i.rs1 = rs1; i.rs2 = rs2; i.imm = imm; i.pc = pc;
    return i;
  endfunction

  function automatic instr_t mk_jump(logic jalr, logic [4:0] rd, logic [4:0] rs1, logic [31:0] imm, logic [31:0] pc);
    instr_t i = bubble();
    i.valid = 1'b1; i.jal = !jalr; i.jalr = jalr; i.imm_sel = jalr; i.rd = rd; i.rs1 = rs1; i.imm = imm; i.pc = pc;
    return i;
  endfunction

  task automatic drive(input instr_t i);
    ex_valid = i.valid; ex_imm_sel = i.imm_sel; ex_subtype = i.sub; ex_memwr = i.memwr;
    ex_mem2reg = i.mem2reg; ex_alu = i.alu; ex_lui = i.lui; ex_auipc = i.auipc;
    ex_jal = i.jal; ex_jalr = i.jalr; ex_branch = i.branch; ex_pc = i.pc; ex_imm = i.imm;
    ex_src1_sel = i.rs1; ex_src2_sel = i.rs2; ex_dst_sel = i.rd; ex_alu_op = i.op;
  endtask

  // Presents one instruction starting just after a rising edge, acks after
  // 'delay' wait cycles, samples outputs mid-cycle and leaves just after an edge.
  task automatic applyStimulus(input instr_t i, input int delay, input logic [31:0] rdata);
    drive(i);
    dmem_rdata = rdata;
    stall_cycles = 0;
    for (int c = 0; c <= delay; c++) begin
      dmem_ack = (i.memwr || i.mem2reg) && (c == delay);
      #3;
      if (c == 0) begin
        samp_redirect = redirect;
        samp_redirect_pc = redirect_pc;
        samp_req = dmem_req;
      end
      if (stall) stall_cycles++;
      @(posedge clk); #1;
    end
    drive(bubble());
    dmem_ack = 1'b0;
  endtask

  task automatic sbPush(input string tag, input logic [31:0] addr, input logic we,
                        input logic [31:0] wdata, input logic [3:0] wstrb);
    mem_exp_t e;
    e.tag = tag; e.addr = addr; e.we = we; e.wdata = wdata; e.wstrb = wstrb;
    sb_q.push_back(e);
  endtask

  // Observe a register by storing it with SW to 0x200 and checking the data.
  task automatic regCheck(input string tag, input logic [4:0] r, input logic [31:0] exp);
    sbPush(tag, 32'h200, 1'b1, exp, 4'hF);
    applyStimulus(mk_store(3'd2, 5'd0, r, 32'h200), 0, 32'd0);
  endtask

  // Memory monitor: every accepted request is compared with the scoreboard head.
  always @(negedge clk) begin
    if (resetb && dmem_req && dmem_ack) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_req_addr", dmem_addr, 32'hFFFF_FFFF);
      end else begin
        mem_exp_t e;
        e = sb_q.pop_front();
        checkOutput({e.tag, "_addr"}, dmem_addr, e.addr);
        checkOutput({e.tag, "_we"}, {31'd0, dmem_we}, {31'd0, e.we});
        if (e.we) begin
          checkOutput({e.tag, "_wdata"}, dmem_wdata, e.wdata);
          checkOutput({e.tag, "_wstrb"}, {28'd0, dmem_wstrb}, {28'd0, e.wstrb});
        end
      end
    end
  end

  initial begin
    vecs[0]  = '{"add",   3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFF3};
    vecs[1]  = '{"sub",   3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFED};
    vecs[2]  = '{"sll",   3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'hFFFF_FF80};
    vecs[3]  = '{"slt",   3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0000_0001};
    vecs[4]  = '{"sltu",  3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0000_0000};
    vecs[5]  = '{"xor",   3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFF3};
    vecs[6]  = '{"srl",   3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h1FFF_FFFE};
    vecs[7]  = '{"sra",   3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFFE};
    vecs[8]  = '{"or",    3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFF3};
    vecs[9]  = '{"and",   3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0000_0000};
    vecs[10] = '{"addi",  3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'd0, 32'h0000_0010};
    vecs[11] = '{"lui",   3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1234_5000, 32'd0, 32'h1234_5000};
    vecs[12] = '{"auipc", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1000, 32'h100, 32'h0000_1100};

    // Reset: outputs stay low even with a load presented.
    resetb = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    drive(bubble());
    repeat (2) @(posedge clk);
    #1 drive(mk_load(3'd2, 5'd3, 5'd0, 32'd0));
    #3;
    checkOutput("rst_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("rst_stall", {31'd0, stall}, 32'd0);
    checkOutput("rst_redirect", {31'd0, redirect}, 32'd0);
    checkOutput("rst_exception", {31'd0, exception}, 32'd0);
    drive(bubble());
    @(posedge clk); #1 resetb = 1'b1;

    // ADDI x1,x0,5 ; ADD x2,x1,x1 back-to-back via bypass.
    applyStimulus(mk_alui(3'd0, 5'd1, 5'd0, 32'd5), 0, 32'd0);
    checkOutput("addi_stall", stall_cycles, 0);
    applyStimulus(mk_alu(3'd0, 1'b0, 5'd2, 5'd1, 5'd1), 0, 32'd0);
    checkOutput("add_stall", stall_cycles, 0);

    // SW x2,0(x0) ; LW x3,0(x0) with a 3-cycle delayed ack.
    sbPush("sw_x2", 32'd0, 1'b1, 32'd10, 4'hF);
    applyStimulus(mk_store(3'd2, 5'd0, 5'd2, 32'd0), 0, 32'd0);
    checkOutput("sw_stall", stall_cycles, 0);
    sbPush("lw_x3", 32'd0, 1'b0, 32'd0, 4'h0);
    applyStimulus(mk_load(3'd2, 5'd3, 5'd0, 32'd0), 3, 32'd10);
    checkOutput("lw_stall_cycles", stall_cycles, 3);
    regCheck("x3", 5'd3, 32'd10);

    // ALU table with x6 = -16, x7 = 3, result in x8.
    applyStimulus(mk_alui(3'd0, 5'd6, 5'd0, 32'hFFFF_FFF0), 0, 32'd0);
    applyStimulus(mk_alui(3'd0, 5'd7, 5'd0, 32'd3), 0, 32'd0);
    for (int v = 0; v < 13; v++) begin
      instr_t i;
      i = mk_alu(vecs[v].op, vecs[v].sub, 5'd8, 5'd6, 5'd7);
      i.imm_sel = vecs[v].imm_sel; i.imm = vecs[v].imm; i.pc = vecs[v].pc;
      if (vecs[v].lui || vecs[v].auipc) begin
        i.alu = 1'b0; i.lui = vecs[v].lui; i.auipc = vecs[v].auipc;
      end
      applyStimulus(i, 0, 32'd0);
      regCheck(vecs[v].name, 5'd8, vecs[v].exp);
    end

    // Byte and half stores/loads with x9 = 0xAB.
    applyStimulus(mk_alui(3'd0, 5'd9, 5'd0, 32'hAB), 0, 32'd0);
    sbPush("sb", 32'd3, 1'b1, 32'hABAB_ABAB, 4'b1000);
    applyStimulus(mk_store(3'd0, 5'd0, 5'd9, 32'd3), 0, 32'd0);
    sbPush("lb", 32'd3, 1'b0, 32'd0, 4'h0);
    applyStimulus(mk_load(3'd0, 5'd4, 5'd0, 32'd3), 1, 32'hAB00_0000);
    regCheck("lb_x4", 5'd4, 32'hFFFF_FFAB);
    sbPush("lbu", 32'd3, 1'b0, 32'd0, 4'h0);
    applyStimulus(mk_load(3'd4, 5'd4, 5'd0, 32'd3), 0, 32'hAB00_0000);
    regCheck("lbu_x4", 5'd4, 32'h0000_00AB);
    sbPush("sh", 32'd2, 1'b1, 32'h00AB_00AB, 4'b1100);
    applyStimulus(mk_store(3'd1, 5'd0, 5'd9, 32'd2), 0, 32'd0);
    sbPush("lh", 32'd2, 1'b0, 32'd0, 4'h0);
    applyStimulus(mk_load(3'd1, 5'd4, 5'd0, 32'd2), 0, 32'h8001_1234);
    regCheck("lh_x4", 5'd4, 32'hFFFF_8001);
    sbPush("lhu", 32'd2, 1'b0, 32'd0, 4'h0);
    applyStimulus(mk_load(3'd5, 5'd4, 5'd0, 32'd2), 0, 32'h8001_1234);
    regCheck("lhu_x4", 5'd4, 32'h0000_8001);

    // BEQ taken with the next instruction killed; BNE not taken.
    applyStimulus(mk_branch(3'd0, 5'd1, 5'd1, 32'd8, 32'h40), 0, 32'd0);
    checkOutput("beq_redirect", {31'd0, samp_redirect}, 32'd1);
    checkOutput("beq_target", samp_redirect_pc, 32'h48);
    applyStimulus(mk_alui(3'd0, 5'd5, 5'd0, 32'd1), 0, 32'd0);
    checkOutput("killed_redirect", {31'd0, samp_redirect}, 32'd0);
    regCheck("killed_x5", 5'd5, 32'd0);
    applyStimulus(mk_branch(3'd1, 5'd1, 5'd1, 32'd8, 32'h40), 0, 32'd0);
    checkOutput("bne_redirect", {31'd0, samp_redirect}, 32'd0);
    applyStimulus(mk_branch(3'd4, 5'd6, 5'd7, 32'h10, 32'h50), 0, 32'd0);
    checkOutput("blt_redirect", {31'd0, samp_redirect}, 32'd1);
    checkOutput("blt_target", samp_redirect_pc, 32'h60);
    applyStimulus(bubble(), 0, 32'd0);
    applyStimulus(mk_branch(3'd6, 5'd6, 5'd7, 32'h10, 32'h50), 0, 32'd0);
    checkOutput("bltu_redirect", {31'd0, samp_redirect}, 32'd0);

    // JAL kills a following store; JALR clears target bit 0.
    applyStimulus(mk_jump(1'b0, 5'd10, 5'd0, 32'h10, 32'h80), 0, 32'd0);
    checkOutput("jal_target", samp_redirect_pc, 32'h90);
    applyStimulus(mk_store(3'd2, 5'd0, 5'd9, 32'h300), 0, 32'd0);
    checkOutput("killed_store_req", {31'd0, samp_req}, 32'd0);
    regCheck("jal_link", 5'd10, 32'h84);
    applyStimulus(mk_jump(1'b1, 5'd11, 5'd7, 32'h21, 32'hC0), 0, 32'd0);
    checkOutput("jalr_redirect", {31'd0, samp_redirect}, 32'd1);
    checkOutput("jalr_target", samp_redirect_pc, 32'h24);
    applyStimulus(bubble(), 0, 32'd0);
    regCheck("jalr_link", 5'd11, 32'hC4);

    // Misaligned LH: no request, no write, sticky exception.
    checkOutput("exc_before", {31'd0, exception}, 32'd0);
    applyStimulus(mk_load(3'd1, 5'd4, 5'd0, 32'h101), 0, 32'hFFFF_FFFF);
    checkOutput("lh_mis_req", {31'd0, samp_req}, 32'd0);
    checkOutput("lh_mis_exc", {31'd0, exception}, 32'd1);
    regCheck("lh_mis_x4", 5'd4, 32'h0000_8001);
    repeat (3) applyStimulus(bubble(), 0, 32'd0);
    checkOutput("exc_sticky", {31'd0, exception}, 32'd1);

    // Reset for one cycle while a load is waiting.
    drive(mk_load(3'd2, 5'd3, 5'd0, 32'd0));
    dmem_ack = 1'b0;
    #3;
    checkOutput("wait_req", {31'd0, dmem_req}, 32'd1);
    checkOutput("wait_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #3;
    resetb = 1'b0;
    #1;
    checkOutput("wait_rst_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("wait_rst_stall", {31'd0, stall}, 32'd0);
    checkOutput("wait_rst_exc", {31'd0, exception}, 32'd0);
    drive(bubble());
    @(posedge clk); #3 resetb = 1'b1;
    @(posedge clk); #1;
    regCheck("rst_x1", 5'd1, 32'd0);
    regCheck("rst_x2", 5'd2, 32'd0);
    regCheck("rst_x3", 5'd3, 32'd0);
    regCheck("rst_x9", 5'd9, 32'd0);

    // Misaligned JAL target: exception, no redirect, no link write.
    applyStimulus(mk_jump(1'b0, 5'd14, 5'd0, 32'd6, 32'h100), 0, 32'd0);
    checkOutput("jal_mis_redirect", {31'd0, samp_redirect}, 32'd0);
    checkOutput("jal_mis_exc", {31'd0, exception}, 32'd1);
    regCheck("jal_mis_x14", 5'd14, 32'd0);

    repeat (2) @(posedge clk);
    checkOutput("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ex_wb_stage.md
# ex_wb_stage

Execute and write-back stages (E, W) of the three-stage RV32I pipeline, directly downstream of fetch/decode. Each cycle it consumes the decoded E-slot fields and resolves operands from an internal 32×32 register file with a W→E bypass. It computes ALU, LUI, AUIPC and jump-link results, resolves branches and jumps into a redirect, runs load/store transactions on the data-memory handshake, and registers results into W for register-file write.

## Interface
- Parameters: none. Datapath is fixed at 32 bits; the register file has 32 entries.
- clk  in  1  pipeline clock
- resetb  in  1  asynchronous, active-low reset
- ex_valid  in  1  E slot holds a real instruction (0 = bubble)
- ex_pc  in  32  PC of the E instruction
- ex_imm  in  32  decoded immediate
- ex_imm_sel  in  1  operand 2 = imm (JALR, LOAD, ARITHI)
- ex_src1_sel / ex_src2_sel / ex_dst_sel  in  5 each  rs1 / rs2 / rd
- ex_alu_op  in  3  func3
- ex_subtype  in  1  SUB/SRA select
- ex_memwr / ex_mem2reg  in  1 each  store / load
- ex_alu, ex_lui, ex_auipc, ex_jal, ex_jalr, ex_branch  in  1 each  instruction class
- stall  out  1  upstream must hold all ex_* inputs stable
- redirect  out  1  taken branch/jump this cycle
- redirect_pc  out  32  target PC; valid only when redirect=1
- dmem_req  out  1  data-memory request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  byte address
- dmem_wdata  out  32  store data, replicated into the selected lanes
- dmem_wstrb  out  4  byte enables
- dmem_ack  in  1  request accepted/completed this cycle
- dmem_rdata  in  32  load word; valid with dmem_ack
- exception  out  1  sticky misaligned load/store or misaligned target

## Operation
- Operands: x0 always reads 0. If wb_we is set and wb_dst equals the source register (and the source is not x0), the operand is wb_data; otherwise it is the register-file value.
- op2 = ex_imm when ex_imm_sel is set, else rs2.
- ALU by func3:
  - 0: ADD, or SUB when subtype
  - 1: SLL by op2[4:0]
  - 2: SLT (signed)
  - 3: SLTU
  - 4: XOR
  - 5: SRL, or SRA when subtype
  - 6: OR
  - 7: AND
- Result selection:
  - LUI: imm
  - AUIPC: pc+imm
  - JAL/JALR: pc+4
- Jump targets: JAL = pc+imm; JALR = (rs1+imm) & ~1.
- Branch by func3: 0 BEQ, 1 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU. func3 2 and 3 are never taken.
- A taken branch, JAL or JALR asserts redirect combinationally in its E cycle. The block then squashes the next E instruction (the wrong-path fetch) via an internal kill flag: no write, no memory request, no redirect.
- A target with target[1:0]≠0 sets exception and produces no redirect.
- Loads/stores compute addr = rs1+imm.
  - Misalignment (H with addr[0]=1, W with addr[1:0]≠0) sets exception; no request and no write occur.
  - Store strobes: SB 4'b0001<<addr[1:0], SH 4'b0011<<addr[1:0], SW 4'b1111.
  - Load extraction: LB/LBU/LH/LHU select the byte/half at addr[1:0], sign- or zero-extended; LW passes the word.
- Memory FSM:
  - IDLE → WAIT when a valid, unkilled load/store issues and dmem_ack=0.
  - WAIT → IDLE on dmem_ack.
  - stall = (mem op in E) && !dmem_ack.
  - dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_wstrb stay constant until ack.
- W register (wb_we, wb_dst, wb_data) loads each non-stalled cycle.
  - wb_we = valid ∧ ¬killed ∧ ¬exception-causing ∧ (alu|lui|auipc|jal|jalr|load) ∧ rd≠0.
  - A stalled cycle loads a bubble (wb_we=0).
- Register file writes wb_data to wb_dst at the clk edge when wb_we is set.
- exception stays set until reset. Instructions after it still execute; the upstream halts the core.

## Timing
- Reset, asynchronous:
  - FSM to IDLE; kill, wb_*, exception and all 32 registers to 0.
  - While resetb is low, all outputs are 0.
  - A reset in WAIT drops dmem_req immediately; the pending ack is ignored.
- ALU-class result latency: E cycle, then visible in W the next cycle.
- The dependent next instruction bypasses with zero bubbles. Load-use also takes zero bubbles, because load data is captured into W on ack.
- A load or store with same-cycle ack costs 1 cycle; each extra wait cycle adds 1 stall cycle.
- Redirect is same-cycle (combinational). The kill flag is registered for exactly one cycle and is cleared by a stall-free advance.
- Redirect and stall are mutually exclusive, since jumps never touch memory.

## Test plan
- Reset then ADDI x1,x0,5 followed by ADD x2,x1,x1 back-to-back → x2=10 via bypass; no stall.
- SW x2,0(x0) then LW x3,0(x0) with ack delayed 3 cycles → stall high 3 cycles, wstrb=4'hF, x3=10.
- SB of 0xAB at addr 3 → wstrb=4'b1000, wdata=0xABABABAB. LB from addr 3 reading 0xAB000000 → x4=0xFFFFFFAB; LBU → 0x000000AB.
- BEQ x1,x1,+8 at pc 0x40 → redirect=1, redirect_pc=0x48; the next E instruction (ADDI x5,x0,1) is killed, x5 stays 0. BNE on the same operands → no redirect.
- LH from addr 0x101 → exception=1, dmem_req never asserted, rd unchanged; exception holds until resetb low.
- resetb low for 1 cycle during WAIT → dmem_req=0 immediately, stall=0, x1..x31=0 after release.
